// File: rtl/move_sequencer_pkg.sv
// move_seq_pkg: state encoding, ramp step sizes and line geometry shared by the move sequencer.
// Also holds the saturating |error| helper used by the heading-settled test.
package move_seq_pkg;

  typedef enum logic [2:0] {IDLE, TURN, RAMP_UP, RAMP_DN, DONE} state_e;

  localparam logic [9:0] INC_SLOW = 10'd4;
  localparam logic [9:0] INC_FAST = 10'd32;
  localparam logic [9:0] DEC_SLOW = 10'd8;
  localparam logic [9:0] DEC_FAST = 10'd64;

  localparam logic [3:0] LINES_PER_SQ = 4'd2;

  // -2048 has no positive twin in 12 bits, so it saturates to 2047.
  function automatic logic [11:0] abs_err(input logic [11:0] e);
    if (e == 12'h800) return 12'h7FF;
    return e[11] ? (~e + 12'd1) : e;
  endfunction

  function automatic logic [3:0] target_of(input logic [2:0] sqrs);
    return {1'b0, sqrs} * LINES_PER_SQ;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: command, heading-sensor, guard-line and PID-drive signals of one move.
// master = command/sensor side, slave = the sequencer.
interface move_sequencer_if;

  logic        cmd_vld;
  logic        cmd_rdy;
  logic [11:0] cmd_hdg;
  logic [2:0]  cmd_sqrs;
  logic [11:0] hdg_actual;
  logic        hdg_vld;
  logic        cntrIR;
  logic        moving;
  logic [9:0]  frwrd;
  logic [11:0] error;
  logic        err_vld;
  logic        done;

  modport master (
    output cmd_vld, cmd_hdg, cmd_sqrs, hdg_actual, hdg_vld, cntrIR,
    input  cmd_rdy, moving, frwrd, error, err_vld, done
  );

  modport slave (
    input  cmd_vld, cmd_hdg, cmd_sqrs, hdg_actual, hdg_vld, cntrIR,
    output cmd_rdy, moving, frwrd, error, err_vld, done
  );

endinterface

// File: rtl/move_sequencer_line_counter.sv
// line_counter: 2-flop sync of the guard-line sensor, rising-edge detect, 4-bit saturating count.
// Latency: count moves 3 cycles after a raw rise; cnt_o shows the count including this cycle's edge.
module line_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] cnt_o
);

  logic       ir_meta_q;
  logic       ir_sync_q;
  logic       ir_prev_q;
  logic       rise;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign rise = ir_sync_q & ~ir_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i && rise && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_meta_q <= 1'b0;
      ir_sync_q <= 1'b0;
      ir_prev_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      ir_meta_q <= ir_i;
      ir_sync_q <= ir_meta_q;
      ir_prev_q <= ir_sync_q;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state view so a same-cycle edge can end the ramp-up before any speed step.
  assign cnt_o = cnt_d;

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: turn, ramp up, count guard lines, ramp down, pulse done; error/err_vld 1 cycle after hdg_vld.
// Backpressure: cmd_rdy only in IDLE; commands offered elsewhere are ignored, never queued.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter bit          FAST_SIM = 1'b0,
  parameter logic [9:0]  MAX_SPD  = 10'h300,
  parameter logic [11:0] ERR_THR  = 12'd30
) (
  input logic             clk,
  input logic             rst,
  move_sequencer_if.slave bus
);

  localparam logic [9:0] INC = FAST_SIM ? INC_FAST : INC_SLOW;
  localparam logic [9:0] DEC = FAST_SIM ? DEC_FAST : DEC_SLOW;

  state_e      state_q, state_d;
  logic [11:0] hdg_des_q, hdg_des_d;
  logic [3:0]  target_q, target_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [11:0] error_q, error_d;
  logic        err_vld_q, err_vld_d;

  logic        accept;
  logic        cnt_en;
  logic [3:0]  line_cnt;
  logic [11:0] err_new;
  logic        settled;
  logic [10:0] spd_sum;

  assign accept  = bus.cmd_vld && (state_q == IDLE);
  assign cnt_en  = (state_q == RAMP_UP) || (state_q == RAMP_DN);
  assign err_new = hdg_des_q - bus.hdg_actual;
  assign settled = bus.hdg_vld && (abs_err(err_new) < ERR_THR);
  assign spd_sum = {1'b0, frwrd_q} + {1'b0, INC};

  line_counter u_lc (
    .clk   (clk),
    .rst   (rst),
    .ir_i  (bus.cntrIR),
    .clr_i (accept),
    .en_i  (cnt_en),
    .cnt_o (line_cnt)
  );

  always_comb begin
    state_d   = state_q;
    hdg_des_d = hdg_des_q;
    target_d  = target_q;
    frwrd_d   = frwrd_q;
    error_d   = bus.hdg_vld ? err_new : error_q;
    err_vld_d = bus.hdg_vld && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        frwrd_d = 10'd0;
        if (accept) begin
          hdg_des_d = bus.cmd_hdg;
          target_d  = target_of(bus.cmd_sqrs);
          state_d   = TURN;
        end
      end
      TURN: begin
        frwrd_d = 10'd0;
        if (settled) begin
          state_d = (target_q != 4'd0) ? RAMP_UP : DONE;
        end
      end
      RAMP_UP: begin
        // Reaching the line target wins over a speed step in the same cycle.
        if (line_cnt == target_q) begin
          state_d = RAMP_DN;
        end else if (bus.hdg_vld) begin
          frwrd_d = (spd_sum > {1'b0, MAX_SPD}) ? MAX_SPD : spd_sum[9:0];
        end
      end
      RAMP_DN: begin
        if (frwrd_q == 10'd0) begin
          state_d = DONE;
        end else if (bus.hdg_vld) begin
          frwrd_d = (frwrd_q >= DEC) ? (frwrd_q - DEC) : 10'd0;
        end
      end
      DONE: begin
        frwrd_d = 10'd0;
        state_d = IDLE;
      end
      default: begin
        frwrd_d = 10'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hdg_des_q <= 12'd0;
      target_q  <= 4'd0;
      frwrd_q   <= 10'd0;
      error_q   <= 12'd0;
      err_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdg_des_q <= hdg_des_d;
      target_q  <= target_d;
      frwrd_q   <= frwrd_d;
      error_q   <= error_d;
      err_vld_q <= err_vld_d;
    end
  end

  assign bus.cmd_rdy = (state_q == IDLE);
  assign bus.moving  = (state_q == TURN) || (state_q == RAMP_UP) || (state_q == RAMP_DN);
  assign bus.frwrd   = frwrd_q;
  assign bus.error   = error_q;
  assign bus.err_vld = err_vld_q;
  assign bus.done    = (state_q == DONE);

  a_done_one_cycle: assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);
  a_spd_ceiling:    assert property (@(posedge clk) disable iff (rst) bus.frwrd <= MAX_SPD);

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer (FAST_SIM=1): directed scenarios plus random moves
// checked against an event-level model of heading error, line counting and speed ramps.
module tb_move_sequencer;

  localparam int M_INC = 32;
  localparam int M_DEC = 64;
  localparam int M_MAX = 768;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  move_sequencer_if bus ();

  move_sequencer #(.FAST_SIM(1'b1), .MAX_SPD(10'h300), .ERR_THR(12'd30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model helpers ----------------
  function automatic logic [11:0] m_err(input int des, input int act);
    return 12'((((des - act) % 4096) + 4096) % 4096);
  endfunction

  function automatic bit m_settled(input logic [11:0] e);
    int s;
    s = (int'(e) >= 2048) ? int'(e) - 4096 : int'(e);
    if (s < 0) s = -s;
    if (s > 2047) s = 2047;
    return s < 30;
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [11:0] hdg, input logic [2:0] sqrs);
    bus.cmd_vld  = 1'b1;
    bus.cmd_hdg  = hdg;
    bus.cmd_sqrs = sqrs;
    tick();
    bus.cmd_vld  = 1'b0;
  endtask

  task automatic pulse(input logic [11:0] act);
    bus.hdg_actual = act;
    bus.hdg_vld    = 1'b1;
    tick();
    bus.hdg_vld    = 1'b0;
  endtask

  task automatic ir_edge();
    bus.cntrIR = 1'b1;
    repeat (3) tick();
    bus.cntrIR = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL reset cmd_rdy: got %b want 1", bus.cmd_rdy); end
    n_vec++; if (bus.moving !== 1'b0) begin n_err++; $display("FAIL reset moving: got %b want 0", bus.moving); end
    n_vec++; if (bus.frwrd !== 10'd0) begin n_err++; $display("FAIL reset frwrd: got %h want 000", bus.frwrd); end
    n_vec++; if (bus.error !== 12'd0) begin n_err++; $display("FAIL reset error: got %h want 000", bus.error); end
    n_vec++; if (bus.err_vld !== 1'b0) begin n_err++; $display("FAIL reset err_vld: got %b want 0", bus.err_vld); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", bus.done); end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    send_cmd(12'h000, 3'd3);
    pulse(12'h000);
    repeat (6) pulse(12'h000);
    n_vec++; if (bus.frwrd !== 10'h0C0) begin n_err++; $display("FAIL midrst pre frwrd: got %h want 0c0", bus.frwrd); end
    rst = 1'b1;
    tick();
    n_vec++; if (bus.frwrd !== 10'd0) begin n_err++; $display("FAIL midrst frwrd: got %h want 000", bus.frwrd); end
    n_vec++; if (bus.moving !== 1'b0) begin n_err++; $display("FAIL midrst moving: got %b want 0", bus.moving); end
    n_vec++; if (bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL midrst cmd_rdy: got %b want 1", bus.cmd_rdy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst done: got %b want 0", bus.done); end
    rst = 1'b0;
    tick();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst done after: got %b want 0", bus.done); end
  endtask

  task automatic test_turn_settle();
    logic [11:0] acts [8];
    logic [11:0] e;
    bit          left;
    acts = '{12'h800, 12'h400, 12'h200, 12'h100, 12'h040, 12'h020, 12'h01E, 12'h010};
    left = 1'b0;
    do_reset();
    send_cmd(12'h000, 3'd1);
    n_vec++; if (bus.err_vld !== 1'b0) begin n_err++; $display("FAIL turn err_vld idle: got %b want 0", bus.err_vld); end
    for (int i = 0; i < 8 && !left; i++) begin
      e = m_err(0, int'(acts[i]));
      pulse(acts[i]);
      n_vec++; if (bus.error !== e) begin n_err++; $display("FAIL turn error[%0d]: got %h want %h", i, bus.error, e); end
      n_vec++; if (bus.err_vld !== 1'b1) begin n_err++; $display("FAIL turn err_vld[%0d]: got %b want 1", i, bus.err_vld); end
      n_vec++; if (bus.frwrd !== 10'd0) begin n_err++; $display("FAIL turn frwrd[%0d]: got %h want 000", i, bus.frwrd); end
      n_vec++; if (bus.moving !== 1'b1) begin n_err++; $display("FAIL turn moving[%0d]: got %b want 1", i, bus.moving); end
      left = m_settled(e);
      if (!left) begin
        tick();
        n_vec++; if (bus.err_vld !== 1'b0) begin n_err++; $display("FAIL turn err_vld drop[%0d]: got %b want 0", i, bus.err_vld); end
      end
    end
    pulse(12'h010);
    n_vec++; if (bus.frwrd !== 10'd32) begin n_err++; $display("FAIL turn first ramp step: got %h want 020", bus.frwrd); end
  endtask

  task automatic test_ramp_sat();
    logic [11:0] des;
    logic [11:0] act;
    int          spd;
    do_reset();
    des = 12'($urandom_range(0, 4095));
    send_cmd(des, 3'd3);
    pulse(des);
    spd = 0;
    for (int k = 1; k <= 40; k++) begin
      act = 12'($urandom_range(0, 4095));
      pulse(act);
      spd = (spd + M_INC > M_MAX) ? M_MAX : spd + M_INC;
      n_vec++; if (bus.frwrd !== 10'(spd)) begin n_err++; $display("FAIL ramp_sat frwrd pulse %0d: got %h want %h", k, bus.frwrd, 10'(spd)); end
      n_vec++; if (bus.error !== m_err(int'(des), int'(act))) begin n_err++; $display("FAIL ramp_sat error pulse %0d: got %h want %h", k, bus.error, m_err(int'(des), int'(act))); end
    end
  endtask

  task automatic test_full_move();
    logic [11:0] des;
    int          spd;
    int          cyc;
    do_reset();
    des = 12'($urandom_range(0, 4095));
    send_cmd(des, 3'd1);
    pulse(des);
    repeat (5) pulse(12'($urandom_range(0, 4095)));
    spd = 5 * M_INC;
    n_vec++; if (bus.frwrd !== 10'(spd)) begin n_err++; $display("FAIL full up frwrd: got %h want %h", bus.frwrd, 10'(spd)); end
    ir_edge();
    pulse(des);
    spd = spd + M_INC;
    n_vec++; if (bus.frwrd !== 10'(spd)) begin n_err++; $display("FAIL full one-line frwrd: got %h want %h", bus.frwrd, 10'(spd)); end
    ir_edge();
    n_vec++; if (bus.frwrd !== 10'(spd)) begin n_err++; $display("FAIL full dn entry frwrd: got %h want %h", bus.frwrd, 10'(spd)); end
    while (spd > 0) begin
      pulse(des);
      spd = (spd >= M_DEC) ? spd - M_DEC : 0;
      n_vec++; if (bus.frwrd !== 10'(spd)) begin n_err++; $display("FAIL full dn frwrd: got %h want %h", bus.frwrd, 10'(spd)); end
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL full early done: got %b want 0", bus.done); end
    end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL full done latency: got %0d cycles want 1", cyc); end
    n_vec++; if (bus.moving !== 1'b0 || bus.frwrd !== 10'd0 || bus.cmd_rdy !== 1'b0) begin n_err++; $display("FAIL full done outputs: moving %b frwrd %h cmd_rdy %b want 0 000 0", bus.moving, bus.frwrd, bus.cmd_rdy); end
    tick();
    n_vec++; if (bus.done !== 1'b0 || bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL full after done: done %b cmd_rdy %b want 0 1", bus.done, bus.cmd_rdy); end
  endtask

  task automatic test_zero_sqrs_wrap();
    logic [11:0] m_des;
    do_reset();
    bus.cmd_vld  = 1'b1;
    bus.cmd_hdg  = 12'h7F0;
    bus.cmd_sqrs = 3'd0;
    tick();
    m_des = 12'h7F0;
    bus.cmd_hdg  = 12'h100;
    bus.cmd_sqrs = 3'd2;
    n_vec++; if (bus.cmd_rdy !== 1'b0 || bus.moving !== 1'b1) begin n_err++; $display("FAIL zero turn: cmd_rdy %b moving %b want 0 1", bus.cmd_rdy, bus.moving); end
    pulse(12'h800);
    n_vec++; if (bus.error !== m_err(int'(m_des), 'h800)) begin n_err++; $display("FAIL zero wrap error: got %h want %h", bus.error, m_err(int'(m_des), 'h800)); end
    n_vec++; if (bus.done !== 1'b1 || bus.frwrd !== 10'd0) begin n_err++; $display("FAIL zero done: done %b frwrd %h want 1 000", bus.done, bus.frwrd); end
    n_vec++; if (bus.cmd_rdy !== 1'b0) begin n_err++; $display("FAIL zero held cmd taken early: cmd_rdy %b want 0", bus.cmd_rdy); end
    tick();
    n_vec++; if (bus.cmd_rdy !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL zero idle: cmd_rdy %b done %b want 1 0", bus.cmd_rdy, bus.done); end
    pulse(12'h000);
    n_vec++; if (bus.error !== m_err(int'(m_des), 0)) begin n_err++; $display("FAIL accept+hdg error: got %h want %h", bus.error, m_err(int'(m_des), 0)); end
    n_vec++; if (bus.err_vld !== 1'b0) begin n_err++; $display("FAIL accept+hdg err_vld: got %b want 0", bus.err_vld); end
    n_vec++; if (bus.moving !== 1'b1) begin n_err++; $display("FAIL second cmd accepted: moving %b want 1", bus.moving); end
    bus.cmd_vld = 1'b0;
    m_des = 12'h100;
    pulse(12'h100);
    n_vec++; if (bus.error !== m_err(int'(m_des), 'h100) || bus.frwrd !== 10'd0) begin n_err++; $display("FAIL second turn: error %h frwrd %h want %h 000", bus.error, bus.frwrd, m_err(int'(m_des), 'h100)); end
    pulse(12'h100);
    n_vec++; if (bus.frwrd !== 10'(M_INC)) begin n_err++; $display("FAIL second ramp: got %h want %h", bus.frwrd, 10'(M_INC)); end
  endtask

  task automatic test_simul_edge();
    logic [11:0] des;
    int          cyc;
    do_reset();
    des = 12'($urandom_range(0, 4095));
    send_cmd(des, 3'd1);
    pulse(des);
    repeat (3) pulse(des);
    n_vec++; if (bus.frwrd !== 10'h060) begin n_err++; $display("FAIL simul pre frwrd: got %h want 060", bus.frwrd); end
    ir_edge();
    bus.cntrIR = 1'b1;
    tick();
    tick();
    pulse(des);
    n_vec++; if (bus.frwrd !== 10'h060) begin n_err++; $display("FAIL simul frwrd: got %h want 060", bus.frwrd); end
    n_vec++; if (dut.u_lc.cnt_q !== 4'd2) begin n_err++; $display("FAIL simul count: got %0d want 2", dut.u_lc.cnt_q); end
    bus.cntrIR = 1'b0;
    pulse(des);
    n_vec++; if (bus.frwrd !== 10'h020) begin n_err++; $display("FAIL simul dn step: got %h want 020", bus.frwrd); end
    pulse(des);
    n_vec++; if (bus.frwrd !== 10'h000) begin n_err++; $display("FAIL simul dn floor: got %h want 000", bus.frwrd); end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL simul done timeout: done %b after %0d cycles", bus.done, cyc); end
    tick();
  endtask

  task automatic test_random_moves();
    logic [11:0] des;
    logic [11:0] act;
    logic [11:0] e;
    int          target;
    int          spd;
    int          cnt;
    int          guard;
    int          cyc;
    bit          settled;
    bit          first;
    do_reset();
    for (int m = 0; m < 5; m++) begin
      des    = 12'($urandom_range(0, 4095));
      target = 2 * int'($urandom_range(1, 3));
      send_cmd(des, 3'(target / 2));
      settled = 1'b0;
      guard   = 0;
      while (!settled && guard < 20) begin
        act = (guard == 19) ? des : 12'(int'(des) + int'($urandom_range(0, 120)) - 60);
        e   = m_err(int'(des), int'(act));
        pulse(act);
        n_vec++; if (bus.error !== e || bus.frwrd !== 10'd0) begin n_err++; $display("FAIL rnd%0d turn: error %h frwrd %h want %h 000", m, bus.error, bus.frwrd, e); end
        settled = m_settled(e);
        guard++;
      end
      spd   = 0;
      cnt   = 0;
      first = 1'b1;
      while (cnt < target) begin
        if (first || $urandom_range(0, 2) != 0) begin
          act = 12'($urandom_range(0, 4095));
          pulse(act);
          spd = (spd + M_INC > M_MAX) ? M_MAX : spd + M_INC;
          n_vec++; if (bus.frwrd !== 10'(spd) || bus.err_vld !== 1'b1 || bus.error !== m_err(int'(des), int'(act))) begin n_err++; $display("FAIL rnd%0d up: frwrd %h err_vld %b error %h want %h 1 %h", m, bus.frwrd, bus.err_vld, bus.error, 10'(spd), m_err(int'(des), int'(act))); end
        end else begin
          ir_edge();
          cnt++;
          n_vec++; if (bus.frwrd !== 10'(spd)) begin n_err++; $display("FAIL rnd%0d edge: frwrd %h want %h", m, bus.frwrd, 10'(spd)); end
        end
        first = 1'b0;
      end
      while (spd > 0) begin
        pulse(12'($urandom_range(0, 4095)));
        spd = (spd >= M_DEC) ? spd - M_DEC : 0;
        n_vec++; if (bus.frwrd !== 10'(spd)) begin n_err++; $display("FAIL rnd%0d dn: frwrd %h want %h", m, bus.frwrd, 10'(spd)); end
      end
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 10) begin tick(); cyc++; end
      n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL rnd%0d done timeout: done %b after %0d cycles", m, bus.done, cyc); end
      tick();
      n_vec++; if (bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rnd%0d cmd_rdy: got %b want 1", m, bus.cmd_rdy); end
    end
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b1;
    n_vec          = 0;
    n_err          = 0;
    bus.cmd_vld    = 1'b0;
    bus.cmd_hdg    = 12'd0;
    bus.cmd_sqrs   = 3'd0;
    bus.hdg_actual = 12'd0;
    bus.hdg_vld    = 1'b0;
    bus.cntrIR     = 1'b0;
    tick();
    test_reset();
    test_reset_mid_move();
    test_turn_settle();
    test_ramp_sat();
    test_full_move();
    test_zero_sqrs_wrap();
    test_simul_edge();
    test_random_moves();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
